// File: rtl/sar_pkg.sv
// Shared definitions for the SAR conversion controller slice.
package sar_pkg;

    localparam int unsigned SAR_WIDTH   = 16;
    localparam int unsigned CONV_CYCLES = SAR_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRACK   = 2'd1,
        CONVERT = 2'd2,
        CAPTURE = 2'd3
    } sar_state_t;

endpackage

// File: rtl/sar_result_reg.sv
// Single-entry valid/ready result register. A new capture always wins;
// overwriting an unconsumed code raises a one-cycle overrun pulse.
module sar_result_reg
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH = SAR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             capture,
    input  logic [WIDTH-1:0] capture_data,
    input  logic             result_ready,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    output logic             overrun
);

    // Capture has priority over consumption; a same-edge consume of the old
    // code keeps valid high and suppresses the overrun pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result       <= '0;
            result_valid <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (capture) begin
                result       <= capture_data;
                result_valid <= 1'b1;
                overrun      <= result_valid & ~result_ready;
            end else if (result_valid && result_ready) begin
                result_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/sar_conv_ctrl.sv
// Conversion sequencer and comparator wrapped around the SAR register:
// tracks/holds the input code, drives the SAR clear, times the bit
// decisions and hands the final code to the result register.
module sar_conv_ctrl
    import sar_pkg::*;
#(
    parameter int unsigned WIDTH         = SAR_WIDTH,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] sample_in,
    input  logic [WIDTH-1:0] sar_value,
    output logic             comparator_out,
    output logic             sar_clear,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic             result_valid,
    input  logic             result_ready,
    output logic             overrun
);

    localparam int unsigned TCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned BCW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [TCW-1:0] TRACK_LAST = TCW'(SETTLE_CYCLES - 1);
    localparam logic [BCW-1:0] BIT_LAST   = BCW'(WIDTH - 1);

    sar_state_t       state, state_d;
    logic [TCW-1:0]   tcnt, tcnt_d;
    logic [BCW-1:0]   bcnt, bcnt_d;
    logic [WIDTH-1:0] held, held_d;
    logic             sar_clear_d;
    logic             capture;

    // State, counters, held sample and the registered SAR clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            tcnt      <= '0;
            bcnt      <= '0;
            held      <= '0;
            sar_clear <= 1'b1;
        end else begin
            state     <= state_d;
            tcnt      <= tcnt_d;
            bcnt      <= bcnt_d;
            held      <= held_d;
            sar_clear <= sar_clear_d;
        end
    end

    // Next-state logic; abort overrides both the TRACK load and the capture.
    always_comb begin
        state_d     = state;
        tcnt_d      = tcnt;
        bcnt_d      = bcnt;
        held_d      = held;
        sar_clear_d = sar_clear;
        capture     = 1'b0;
        case (state)
            IDLE: begin
                sar_clear_d = 1'b1;
                if (start) begin
                    state_d = TRACK;
                    tcnt_d  = '0;
                end
            end
            TRACK: begin
                if (abort) begin
                    state_d     = IDLE;
                    sar_clear_d = 1'b1;
                end else begin
                    held_d = sample_in;
                    if (tcnt == TRACK_LAST) begin
                        state_d     = CONVERT;
                        sar_clear_d = 1'b0;
                        bcnt_d      = '0;
                    end else begin
                        tcnt_d = tcnt + 1'b1;
                    end
                end
            end
            CONVERT: begin
                if (abort) begin
                    state_d     = IDLE;
                    sar_clear_d = 1'b1;
                end else if (bcnt == BIT_LAST) begin
                    state_d = CAPTURE;
                end else begin
                    bcnt_d = bcnt + 1'b1;
                end
            end
            CAPTURE: begin
                state_d     = IDLE;
                sar_clear_d = 1'b1;
                capture     = ~abort;
            end
            default: begin
                state_d     = IDLE;
                sar_clear_d = 1'b1;
            end
        endcase
    end

    assign busy           = (state != IDLE);
    assign comparator_out = (held >= sar_value);

    sar_result_reg #(
        .WIDTH(WIDTH)
    ) u_result_reg (
        .clk          (clk),
        .rst          (rst),
        .capture      (capture),
        .capture_data (sar_value),
        .result_ready (result_ready),
        .result       (result),
        .result_valid (result_valid),
        .overrun      (overrun)
    );

endmodule

// File: doc/sar_conv_ctrl.md
# sar_conv_ctrl

Conversion sequencer and comparator for the 16-bit SAR converter. It tracks and holds the digital input sample (CORDIC sine code acting as the analog stand-in) and drives the SAR register's reset (`sar_clear`). It supplies the trial-bit decision (`comparator_out`), times the 16 bit-decision cycles, and captures the final code into a valid/ready output register. It sits directly around the SAR register: upstream as its comparator and reset source, downstream as its result consumer.

## Interface
- `WIDTH`, 16: sample/result width; also the number of bit-decision cycles.
- `SETTLE_CYCLES`, 2: track cycles before hold; legal values are 1 or more.

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `start`  in  1  conversion request; sampled in IDLE only
- `abort`  in  1  synchronous cancel of an in-flight conversion
- `sample_in`  in  WIDTH  input code, continuously driven
- `sar_value`  in  WIDTH  SAR register trial/result value
- `comparator_out`  out  1  trial decision to the SAR register
- `sar_clear`  out  1  registered; drives the SAR register `rst` (high = hold at 0x8000)
- `busy`  out  1  high in any state other than IDLE
- `result`  out  WIDTH  captured conversion code
- `result_valid`  out  1  `result` holds an unconsumed code
- `result_ready`  in  1  consumer accepts `result`
- `overrun`  out  1  one-cycle pulse when an unconsumed result is overwritten

## Operation
- States: IDLE, TRACK, CONVERT, CAPTURE.
- **IDLE**
  - `sar_clear`=1.
  - `start`=1 → TRACK, track counter = 0.
- **TRACK**
  - `held` <= `sample_in` every cycle.
  - After SETTLE_CYCLES edges → CONVERT.
  - On that same edge: `sar_clear` <= 0, `held` takes its final load, bit counter = 0.
- **CONVERT**
  - `held` is frozen.
  - Exactly WIDTH cycles, counted 0..WIDTH-1, then → CAPTURE.
- **CAPTURE**
  - One cycle.
  - On its closing edge: `result` <= `sar_value`, `result_valid` <= 1, `sar_clear` <= 1, state → IDLE.
- Comparator: `comparator_out` = (`held` >= `sar_value`), unsigned, combinational, all states.
  - Consequence: the final code equals `held` exactly.
- The extra SAR edge in CAPTURE may modify bit 0 of `sar_value` after the capture edge. This is harmless: the capture uses the pre-edge value.
- `start` while `busy` is ignored, with no queueing.
- `abort` in TRACK, CONVERT or CAPTURE:
  - Next edge → IDLE, `sar_clear` <= 1.
  - No capture; `result`/`result_valid` are untouched.
  - `abort` has priority over the CAPTURE load in the same cycle.
- Output handshake: a transfer occurs on any edge where `result_valid` && `result_ready`. `result_valid` then clears unless a capture lands on the same edge.
- Capture with `result_valid`=1 and `result_ready`=0: new code overwrites, `overrun` pulses 1 cycle.
- Capture with `result_valid`=1 and `result_ready`=1 in the same cycle: the old code is consumed, the new one is loaded, `result_valid` stays 1, no `overrun`.
- Reset values:
  - state IDLE
  - `sar_clear` 1
  - `busy` 0
  - `result` 0
  - `result_valid` 0
  - `overrun` 0
  - `held` 0
  - counters 0
- `rst` mid-conversion aborts immediately; no partial result.

## Timing
- `start` sampled at edge E0.
- Edges E1..E(SETTLE_CYCLES) are TRACK loads; the final held value = `sample_in` at edge E(SETTLE_CYCLES).
- `sar_clear` falls after edge E(SETTLE_CYCLES).
- SAR decision edges are E(S+1)..E(S+16).
- CAPTURE edge is E(S+17). `result_valid` is visible after it.
  - With defaults, that is 19 cycles after `start`.
- `busy` is high from after E0 through E(S+17).
- The next `start` is accepted in the cycle after E(S+17).
  - Back-to-back throughput: one conversion per S+18 cycles.
- `sar_clear` is a flop output (glitch-free), safe to drive an async reset. Deassertion is synchronous to `clk`.
- `comparator_out` settles combinationally within the same cycle as `sar_value`.

## Structure
- Package `sar_pkg`:
  - `SAR_WIDTH` = 16
  - state enum `sar_state_t` {IDLE, TRACK, CONVERT, CAPTURE}
  - `CONV_CYCLES` = `SAR_WIDTH`
- One natural sub-module, `sar_result_reg`. It holds the single-entry valid/ready output register with overwrite and `overrun` pulse, instantiated once.
- The FSM, counters, `held` register and comparator stay in the top.

## Test plan
- **Full conversion.** Reset, `sample_in`=0x1234, `start` pulse, with the SAR register model connected.
  - `result_valid` rises 19 cycles after `start`.
  - `result`=0x1234.
  - `sar_clear` is low for exactly 17 cycles.
- **Range extremes.** `sample_in`=0xFFFF, then 0x0000, then 0x8000.
  - Results are 0xFFFF, 0x0000 and 0x8000.
  - `comparator_out` sequence for 0x8000 is 1,0,0,…,0.
- **Hold.** `sample_in` changes to 0x5555 during CONVERT, after being 0x00FF at the last TRACK edge.
  - `result`=0x00FF.
- **Overrun.** Two conversions with `result_ready`=0.
  - Second capture overwrites, `overrun` pulses once.
- **Same-cycle accept.** `result_ready`=1 on the second capture cycle.
  - No `overrun`, `result_valid` stays 1.
- **Abort and reset.** `abort` at CONVERT bit 7 → IDLE next cycle, `sar_clear`=1, prior `result` unchanged. `start` during `busy` ignored. `rst` mid-CONVERT → all outputs at their reset values.
